product_host_driver: RTL

Host-side initiator for the nibble-serial 8x8 multiplier tile. Accepts two 8-bit operands on a valid/ready input, generates the tile's clock, reset and nibble pins, sequences the 4-nibble load / compute / 2-byte readout protocol, and returns the 16-bit product on a valid/ready output. It sits on the system clock domain between a test or host controller and the tile's `io_in`/`io_out` pins.

---
 rtl/product_host_driver.sv | 114 +++++++++++
 1 files changed

// File: rtl/product_host_driver.sv
// product_host_driver: host-side sequencer for the nibble-serial 8x8 multiplier tile
module product_host_driver #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [7:0]  tile_io_in,
  input  logic [7:0]  tile_io_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [7:0] DM1 = 8'(CLK_DIV - 1);
  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic        hi_q, hi_d;
  logic [2:0]  k_q, k_d;
  logic [7:0]  a_q, a_d, b_q, b_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] result_q, result_d;
  logic [7:0]  io_q, io_d;
  logic        wrap, nhi;
  logic [7:0]  ndiv;
  logic [2:0]  nk;
  logic [3:0]  nib;
  // Advance the pulse position one cycle ahead so the registered pins match the current cycle
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    hi_d        = hi_q;
    k_d         = k_q;
    a_d         = a_q;
    b_d         = b_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    io_d        = io_q;
    wrap        = div_q == DM1;
    ndiv        = wrap ? 8'd0 : div_q + 8'd1;
    nhi         = wrap ? ~hi_q : hi_q;
    nk          = (wrap && hi_q) ? k_q + 3'd1 : k_q;
    nib         = nk == 3'd1 ? a_q[7:4] :
                  nk == 3'd2 ? a_q[3:0] :
                  nk == 3'd3 ? b_q[7:4] :
                  nk == 3'd4 ? b_q[3:0] : 4'h0;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d    = RUN;
        a_d        = a;
        b_d        = b;
        in_ready_d = 1'b0;
        div_d      = 8'd0;
        hi_d       = 1'b0;
        k_d        = 3'd0;
        io_d       = 8'h02;
      end
      RUN: begin
        div_d = ndiv;
        hi_d  = nhi;
        k_d   = nk;
        io_d  = {nib, 2'b00, nk == 3'd0, nhi};
        if (k_q == 3'd6 && !hi_q && wrap) result_d[15:8] = tile_io_out;
        if (k_q == 3'd7 && wrap) begin
          result_d[7:0] = tile_io_out;
          state_d       = DONE;
          out_valid_d   = 1'b1;
          io_d          = 8'h00;
        end
      end
      DONE: if (out_ready) begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      div_q       <= 8'd0;
      hi_q        <= 1'b0;
      k_q         <= 3'd0;
      a_q         <= 8'd0;
      b_q         <= 8'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= 16'd0;
      io_q        <= 8'd0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      hi_q        <= hi_d;
      k_q         <= k_d;
      a_q         <= a_d;
      b_q         <= b_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      io_q        <= io_d;
    end
  end
  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign result     = result_q;
  assign tile_io_in = io_q;
endmodule
